address_unit: RTL and testbench

//  16-bit address generation stage directly downstream of the 6502 control unit. Holds PC and MAR.

---
 rtl/address_unit_if.sv | 42 ++++
 rtl/address_unit.sv | 109 ++++++++++
 tb/tb_address_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/address_unit_if.sv
// address_unit_if
//   Bus bundle between the 6502 control unit (master) and the address
//   generation stage (slave).
//   master drives: DATA_IN, OFFSET, SELECT_ADDRESS, VEC_HI and the
//                  PC/MAR/offset strobes
//   slave drives:  ADDRESS, PC_OUT, MAR_OUT, BUSY, PAGE_CROSS
interface address_unit_if;
  logic [7:0]  DATA_IN;
  logic [7:0]  OFFSET;
  logic [1:0]  SELECT_ADDRESS;
  logic        VEC_HI;
  logic        reset_PC;
  logic        load_PC;
  logic        inc_PC;
  logic        reset_MAR;
  logic        load_MARL;
  logic        load_MARH;
  logic        load_offset;
  logic        reset_offset;
  logic        ZP_WRAP;
  logic [15:0] ADDRESS;
  logic [15:0] PC_OUT;
  logic [15:0] MAR_OUT;
  logic        BUSY;
  logic        PAGE_CROSS;

  modport master (
    output DATA_IN, OFFSET, SELECT_ADDRESS, VEC_HI,
    output reset_PC, load_PC, inc_PC,
    output reset_MAR, load_MARL, load_MARH,
    output load_offset, reset_offset, ZP_WRAP,
    input  ADDRESS, PC_OUT, MAR_OUT, BUSY, PAGE_CROSS
  );

  modport slave (
    input  DATA_IN, OFFSET, SELECT_ADDRESS, VEC_HI,
    input  reset_PC, load_PC, inc_PC,
    input  reset_MAR, load_MARL, load_MARH,
    input  load_offset, reset_offset, ZP_WRAP,
    output ADDRESS, PC_OUT, MAR_OUT, BUSY, PAGE_CROSS
  );
endinterface

// File: rtl/address_unit.sv
// address_unit
//   16-bit address generation stage behind the 6502 control unit. Holds PC
//   and MAR, executes the controller's strobes, performs indexed addition
//   MAR += OFFSET with a one-cycle high-byte fix-up on page cross, and drives
//   the memory address bus.
//   Ports:
//     CLK    system clock, all state changes on the rising edge
//     RESET  synchronous active-high reset, overrides every strobe
//     bus    address_unit_if.slave: data/offset inputs, address select,
//            strobes in; ADDRESS, PC_OUT, MAR_OUT, BUSY, PAGE_CROSS out
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | accepting strobes; load_offset performs the low-byte add
//   FIX   | low byte already updated, MAR high byte increments next edge
module address_unit #(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter logic [15:0] VECTOR_BASE = 16'hFFFC
) (
  input logic           CLK,
  input logic           RESET,
  address_unit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FIX  = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] mar, mar_n;
  logic        page_cross, page_cross_n;
  logic [8:0]  sum;

  assign sum = {1'b0, mar[7:0]} + {1'b0, bus.OFFSET};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      mar        <= 16'h0000;
      page_cross <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      mar        <= mar_n;
      page_cross <= page_cross_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    mar_n        = mar;
    page_cross_n = page_cross;

    // load_PC samples the current MAR, never the value being written this edge
    if (bus.reset_PC)     pc_n = PC_RESET;
    else if (bus.load_PC) pc_n = mar;
    else if (bus.inc_PC)  pc_n = pc + 16'd1;

    // Indexed update first; explicit MAR strobes below override it per byte
    unique case (state)
      IDLE: begin
        if (bus.reset_offset) begin
          page_cross_n = 1'b0;
        end else if (bus.load_offset) begin
          mar_n[7:0] = sum[7:0];
          if (sum[8] && !bus.ZP_WRAP) begin
            page_cross_n = 1'b1;
            state_n      = FIX;
          end
        end
      end
      FIX: begin
        state_n = IDLE;
        if (bus.reset_offset) begin
          page_cross_n = 1'b0;
        end else if (!bus.load_MARH && !bus.reset_MAR) begin
          mar_n[15:8] = mar[15:8] + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (bus.reset_MAR) begin
      mar_n = 16'h0000;
    end else begin
      if (bus.load_MARL) mar_n[7:0]  = bus.DATA_IN;
      if (bus.load_MARH) mar_n[15:8] = bus.DATA_IN;
    end
  end

  always_comb begin
    unique case (bus.SELECT_ADDRESS)
      2'b00:   bus.ADDRESS = pc;
      2'b01:   bus.ADDRESS = mar;
      2'b10:   bus.ADDRESS = {8'h00, mar[7:0]};
      default: bus.ADDRESS = VECTOR_BASE + {15'd0, bus.VEC_HI};
    endcase
  end

  assign bus.PC_OUT     = pc;
  assign bus.MAR_OUT    = mar;
  assign bus.BUSY       = (state == FIX);
  assign bus.PAGE_CROSS = page_cross;

endmodule

// File: tb/tb_address_unit.sv
module tb_address_unit;
  logic CLK;
  logic RESET;
  int   total;
  int   bad;

  address_unit_if bus ();

  address_unit #(
    .PC_RESET    (16'h0000),
    .VECTOR_BASE (16'hFFFC)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    bus.reset_PC     = 1'b0;
    bus.load_PC      = 1'b0;
    bus.inc_PC       = 1'b0;
    bus.reset_MAR    = 1'b0;
    bus.load_MARL    = 1'b0;
    bus.load_MARH    = 1'b0;
    bus.load_offset  = 1'b0;
    bus.reset_offset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one byte into MAR low or high and clock it in
  task automatic set_marl(input logic [7:0] d);
    bus.DATA_IN = d; bus.load_MARL = 1'b1; tick(); clr();
  endtask

  task automatic set_marh(input logic [7:0] d);
    bus.DATA_IN = d; bus.load_MARH = 1'b1; tick(); clr();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr();
    bus.DATA_IN        = 8'h00;
    bus.OFFSET         = 8'h00;
    bus.SELECT_ADDRESS = 2'b00;
    bus.VEC_HI         = 1'b0;
    bus.ZP_WRAP        = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;

    // reset state
    check("rst_pc",    bus.PC_OUT,     16'h0000);
    check("rst_mar",   bus.MAR_OUT,    16'h0000);
    check("rst_busy",  bus.BUSY,       16'h0);
    check("rst_pcx",   bus.PAGE_CROSS, 16'h0);
    check("rst_addr",  bus.ADDRESS,    16'h0000);

    // PC increment wrap
    set_marl(8'hFE);
    set_marh(8'hFF);
    bus.load_PC = 1'b1; tick(); clr();
    check("pc_load_fffe", bus.PC_OUT, 16'hFFFE);
    bus.inc_PC = 1'b1; tick();
    check("pc_inc_ffff", bus.PC_OUT, 16'hFFFF);
    tick(); clr();
    check("pc_inc_wrap", bus.PC_OUT, 16'h0000);

    // load_PC beats inc_PC
    set_marl(8'h34);
    set_marh(8'h12);
    bus.inc_PC = 1'b1; bus.load_PC = 1'b1; tick(); clr();
    check("pc_load_prio", bus.PC_OUT, 16'h1234);

    // load_PC takes MAR before a same-edge MAR write
    bus.load_PC = 1'b1; bus.load_MARL = 1'b1; bus.DATA_IN = 8'h99; tick(); clr();
    check("pc_old_mar", bus.PC_OUT,  16'h1234);
    check("mar_l99",    bus.MAR_OUT, 16'h1299);

    // indexed add, no page cross
    set_marl(8'h34);
    set_marh(8'h12);
    bus.OFFSET = 8'h05; bus.load_offset = 1'b1; tick(); clr();
    check("idx_nocross_mar",  bus.MAR_OUT, 16'h1239);
    check("idx_nocross_busy", bus.BUSY,    16'h0);
    check("idx_nocross_pcx",  bus.PAGE_CROSS, 16'h0);
    tick();
    check("idx_nocross_busy2", bus.BUSY, 16'h0);

    // indexed add with page cross
    set_marl(8'hF0);
    bus.OFFSET = 8'h20; bus.load_offset = 1'b1; tick(); clr();
    check("cross_mar1",  bus.MAR_OUT,    16'h1210);
    check("cross_busy1", bus.BUSY,       16'h1);
    check("cross_pcx1",  bus.PAGE_CROSS, 16'h1);
    tick();
    check("cross_mar2",  bus.MAR_OUT,    16'h1310);
    check("cross_busy2", bus.BUSY,       16'h0);
    check("cross_pcx2",  bus.PAGE_CROSS, 16'h1);
    bus.SELECT_ADDRESS = 2'b01; #1;
    check("addr_mar", bus.ADDRESS, 16'h1310);
    bus.SELECT_ADDRESS = 2'b10; #1;
    check("addr_zp",  bus.ADDRESS, 16'h0010);
    bus.SELECT_ADDRESS = 2'b00;
    bus.reset_offset = 1'b1; tick(); clr();
    check("pcx_clear", bus.PAGE_CROSS, 16'h0);

    // zero-page wrap vs full carry at top of memory
    set_marl(8'hF0);
    set_marh(8'hFF);
    bus.ZP_WRAP = 1'b1; bus.OFFSET = 8'h20; bus.load_offset = 1'b1; tick(); clr();
    check("zp_mar",  bus.MAR_OUT,    16'hFF10);
    check("zp_busy", bus.BUSY,       16'h0);
    check("zp_pcx",  bus.PAGE_CROSS, 16'h0);
    bus.ZP_WRAP = 1'b0;
    set_marl(8'hF0);
    bus.load_offset = 1'b1; tick();
    check("wrap_busy", bus.BUSY,    16'h1);
    check("wrap_mar1", bus.MAR_OUT, 16'hFF10);
    tick(); clr();   // load_offset held during FIX must be ignored
    check("wrap_mar2", bus.MAR_OUT, 16'h0010);
    check("wrap_idle", bus.BUSY,    16'h0);

    // load_MARH during FIX wins over the increment
    set_marl(8'hF0);
    set_marh(8'h12);
    bus.load_offset = 1'b1; tick(); clr();
    check("fixh_busy", bus.BUSY, 16'h1);
    bus.DATA_IN = 8'hAB; bus.load_MARH = 1'b1; tick(); clr();
    check("fixh_mar",  bus.MAR_OUT, 16'hAB10);
    check("fixh_idle", bus.BUSY,    16'h0);
    tick();
    check("fixh_mar2", bus.MAR_OUT, 16'hAB10);

    // reset_offset during FIX aborts the increment
    set_marl(8'hF0);
    set_marh(8'h12);
    bus.load_offset = 1'b1; tick(); clr();
    bus.reset_offset = 1'b1; tick(); clr();
    check("abort_mar",  bus.MAR_OUT,    16'h1210);
    check("abort_busy", bus.BUSY,       16'h0);
    check("abort_pcx",  bus.PAGE_CROSS, 16'h0);

    // reset_offset beats load_offset in IDLE
    bus.reset_offset = 1'b1; bus.load_offset = 1'b1; tick(); clr();
    check("roff_prio_mar", bus.MAR_OUT, 16'h1210);
    check("roff_prio_busy", bus.BUSY,   16'h0);

    // RESET during FIX clears everything
    set_marl(8'hF0);
    bus.inc_PC = 1'b1; bus.load_offset = 1'b1; tick(); clr();
    check("pre_rst_busy", bus.BUSY, 16'h1);
    RESET = 1'b1; bus.inc_PC = 1'b1; tick(); clr(); RESET = 1'b0;
    check("fixrst_pc",   bus.PC_OUT,     16'h0000);
    check("fixrst_mar",  bus.MAR_OUT,    16'h0000);
    check("fixrst_busy", bus.BUSY,       16'h0);
    check("fixrst_pcx",  bus.PAGE_CROSS, 16'h0);

    // vector select
    bus.SELECT_ADDRESS = 2'b11; bus.VEC_HI = 1'b1; #1;
    check("vec_hi", bus.ADDRESS, 16'hFFFD);
    bus.VEC_HI = 1'b0; #1;
    check("vec_lo", bus.ADDRESS, 16'hFFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
